// File: rtl/alu_64bit_ctrl.sv
// alu_64bit_ctrl
// ----------------------------------------------------------------------------
// Execute-stage 64-bit ALU with its integrated ALU control decoder. ALUOp and
// {funct7[5], funct3} decode combinationally into a 4-bit operation. The
// operation runs on operands a/b, and result, flags and the decoded operation
// are registered on every clock edge where in_valid is high (1-cycle latency).
// The same core also serves as the fixed-add branch-target adder (alu_op=00).
//
// Optional feature macro: ALU_SLT_EN
//   defined   : alu_op=1x, func=0010 decodes to signed set-less-than (0111)
//   undefined : func=0010 is unmapped (operation 1111, illegal=1, result 0)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands/controls valid; captures a new result
//   alu_op     in   2   main-control ALUOp
//   func       in   4   {funct7[5], funct3}
//   a          in  64   operand A (rs1 or PC)
//   b          in  64   operand B (rs2 or immediate)
//   out_valid  out  1   result registers were updated on the last edge
//   result     out 64   registered ALU result
//   zero       out  1   registered, result == 0
//   overflow   out  1   registered signed overflow (add/sub only)
//   operation  out  4   registered decoded operation
//   illegal    out  1   registered, func code was unmapped
// ----------------------------------------------------------------------------
module alu_64bit_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  alu_op,
  input  logic [3:0]  func,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  output logic [63:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [3:0]  operation,
  output logic        illegal
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 4;

  // Operation encodings driven to the ALU core.
  localparam logic [OP_W-1:0] OP_AND     = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB     = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT     = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR     = 4'b1100;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

  // Function-field codes recognised for R-type decode.
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b1000;
  localparam logic [3:0] FN_AND = 4'b0111;
  localparam logic [3:0] FN_OR  = 4'b0110;
  localparam logic [3:0] FN_SLT = 4'b0010;

  // --------------------------------------------------------------------------
  // Combinational control decode
  // --------------------------------------------------------------------------
  logic [OP_W-1:0] op_c;
  logic            illegal_c;

  always_comb begin
    op_c      = OP_ILLEGAL;
    illegal_c = 1'b0;
    unique case (alu_op)
      2'b00: op_c = OP_ADD;
      2'b01: op_c = OP_SUB;
      default: begin
        // alu_op = 1x: R-type, decode the function field
        case (func)
          FN_ADD: op_c = OP_ADD;
          FN_SUB: op_c = OP_SUB;
          FN_AND: op_c = OP_AND;
          FN_OR:  op_c = OP_OR;
`ifdef ALU_SLT_EN
          FN_SLT: op_c = OP_SLT;
`endif
          default: begin
            op_c      = OP_ILLEGAL;
            illegal_c = 1'b1;
          end
        endcase
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared adder: subtraction reuses it as a + ~b + 1
  // --------------------------------------------------------------------------
  logic              is_sub_c;
  logic [DATA_W-1:0] b_eff_c;
  logic [DATA_W-1:0] sum_c;
  logic              add_ovf_c;

  always_comb begin
    is_sub_c  = (op_c == OP_SUB);
    b_eff_c   = is_sub_c ? ~b : b;
    sum_c     = a + b_eff_c + DATA_W'(is_sub_c);
    // Operands of equal sign (after inversion for sub) producing a result of
    // the other sign; covers both the add and the sub overflow rule.
    add_ovf_c = (a[DATA_W-1] == b_eff_c[DATA_W-1]) &&
                (sum_c[DATA_W-1] != a[DATA_W-1]);
  end

  // --------------------------------------------------------------------------
  // ALU core: operation select and flags
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_res_c;
  logic              alu_ovf_c;

  always_comb begin
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (op_c)
      OP_AND: alu_res_c = a & b;
      OP_OR:  alu_res_c = a | b;
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = add_ovf_c;
      end
      OP_SUB: begin
        alu_res_c = sum_c;
        alu_ovf_c = add_ovf_c;
      end
      // NOR is only reachable through a future decode extension.
      OP_NOR: alu_res_c = ~(a | b);
`ifdef ALU_SLT_EN
      OP_SLT: alu_res_c = DATA_W'($signed(a) < $signed(b));
`endif
      default: alu_res_c = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register next-state: capture on in_valid, otherwise hold
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] result_d,    result_q;
  logic              zero_d,      zero_q;
  logic              overflow_d,  overflow_q;
  logic [OP_W-1:0]   operation_d, operation_q;
  logic              illegal_d,   illegal_q;
  logic              out_valid_d, out_valid_q;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    operation_d = operation_q;
    illegal_d   = illegal_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d    = alu_res_c;
      zero_d      = ~|alu_res_c;
      overflow_d  = alu_ovf_c;
      operation_d = op_c;
      illegal_d   = illegal_c;
    end
  end

  // Output registers; async reset discards any in-flight capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      operation_q <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      operation_q <= operation_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign operation = operation_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_64bit_ctrl.sv
// tb_alu_64bit_ctrl
// Directed bench for alu_64bit_ctrl with hand-computed expectations.
module tb_alu_64bit_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [3:0]  func;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic [63:0] result;
  logic        zero;
  logic        overflow;
  logic [3:0]  operation;
  logic        illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_64bit_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .alu_op    (alu_op),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .operation (operation),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every registered output at once.
  task automatic check_all(input string tag, input logic ov, input logic [63:0] res,
                           input logic z, input logic of, input logic [3:0] op,
                           input logic il);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".result"},    result,         res);
    check({tag, ".zero"},      64'(zero),      64'(z));
    check({tag, ".overflow"},  64'(overflow),  64'(of));
    check({tag, ".operation"}, 64'(operation), 64'(op));
    check({tag, ".illegal"},   64'(illegal),   64'(il));
  endtask

  // Apply one transaction, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [3:0] fn,
                      input logic [63:0] av, input logic [63:0] bv);
    in_valid = v;
    alu_op   = op;
    func     = fn;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random inputs
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 2'($urandom);
    func     = 4'($urandom);
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    repeat (3) begin
      @(posedge clk);
      #1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
    end
    check_all("reset", 1'b0, 64'h0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Release with no in_valid: outputs stay cleared
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 2'b00, 4'h0, 64'h55, 64'h66);
    step(1'b0, 2'b00, 4'h0, 64'h55, 64'h66);
    check_all("idle", 1'b0, 64'h0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // Add path with signed overflow
    step(1'b1, 2'b00, 4'hF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    check_all("add_ovf", 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b0010, 1'b0);

    // Add of two negatives wrapping to zero
    step(1'b1, 2'b00, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    check_all("add_wrap", 1'b1, 64'h0, 1'b1, 1'b1, 4'b0010, 1'b0);

    // Branch compare (func ignored for alu_op=01)
    step(1'b1, 2'b01, 4'h7, 64'h1234, 64'h1234);
    check_all("beq_eq", 1'b1, 64'h0, 1'b1, 1'b0, 4'b0110, 1'b0);
    step(1'b1, 2'b01, 4'h0, 64'h5, 64'h7);
    check_all("beq_ne", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0110, 1'b0);

    // R-type decode
    step(1'b1, 2'b10, 4'b0111, 64'hF0F0, 64'hFF00);
    check_all("r_and", 1'b1, 64'hF000, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 2'b10, 4'b0110, 64'hF0F0, 64'hFF00);
    check_all("r_or", 1'b1, 64'hFFF0, 1'b0, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 2'b10, 4'b1000, 64'h8000_0000_0000_0000, 64'h1);
    check_all("r_sub_ovf", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 2'b11, 4'b0000, 64'h10, 64'h22);
    check_all("r_add_op11", 1'b1, 64'h32, 1'b0, 1'b0, 4'b0010, 1'b0);

    // Unmapped function code
    step(1'b1, 2'b10, 4'b0101, 64'hDEAD, 64'hBEEF);
    check_all("r_illegal", 1'b1, 64'h0, 1'b1, 1'b0, 4'b1111, 1'b1);

    // func=0010: SLT when enabled, otherwise unmapped
    step(1'b1, 2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
`ifdef ALU_SLT_EN
    check_all("slt", 1'b1, 64'h1, 1'b0, 1'b0, 4'b0111, 1'b0);
`else
    check_all("slt_off", 1'b1, 64'h0, 1'b1, 1'b0, 4'b1111, 1'b1);
`endif

    // Back-to-back adds, then hold
    step(1'b1, 2'b00, 4'h0, 64'd1, 64'd2);
    check_all("tp0", 1'b1, 64'd3, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(1'b1, 2'b00, 4'h0, 64'd10, 64'd20);
    check_all("tp1", 1'b1, 64'd30, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(1'b1, 2'b00, 4'h0, 64'd100, 64'd200);
    check_all("tp2", 1'b1, 64'd300, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(1'b0, 2'b01, 4'h7, 64'd7, 64'd9);
    check_all("hold0", 1'b0, 64'd300, 1'b0, 1'b0, 4'b0010, 1'b0);
    step(1'b0, 2'b10, 4'h5, 64'd0, 64'd0);
    check_all("hold1", 1'b0, 64'd300, 1'b0, 1'b0, 4'b0010, 1'b0);

    // Reset mid-stream: clears at once and discards the pending capture
    in_valid = 1'b1;
    alu_op   = 2'b00;
    func     = 4'h0;
    a        = 64'h7FFF_FFFF_FFFF_FFFF;
    b        = 64'h1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 64'h0, 1'b0, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 1'b0, 64'h0, 1'b0, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 2'b10, 4'b1000, 64'd9, 64'd4);
    check_all("post_rst", 1'b1, 64'd5, 1'b0, 1'b0, 4'b0110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
